// File: rtl/memlcd_pkg.sv
// rtl/memlcd_pkg.sv - shared geometry, thresholds, state and word layout for the memory-LCD path
package memlcd_pkg;

   localparam int H_PIXELS_DEFAULT = 240;
   localparam int V_LINES_DEFAULT  = 640;
   localparam int WORDS_PER_LINE   = H_PIXELS_DEFAULT / 2;

   // 2x2 ordered-dither thresholds, named T<x0><y0>
   localparam logic [7:0] BAYER_T00       = 8'd32;
   localparam logic [7:0] BAYER_T10       = 8'd160;
   localparam logic [7:0] BAYER_T01       = 8'd224;
   localparam logic [7:0] BAYER_T11       = 8'd96;
   localparam logic [7:0] FIXED_THRESHOLD = 8'd128;

   // Each pixel contributes {B,G,R}; the even pixel sits in the low half of the word
   localparam int HALF_BITS     = 3;
   localparam int WORD_BITS     = 2 * HALF_BITS;
   localparam int WORD_LSB_PIX0 = 0;
   localparam int WORD_LSB_PIX1 = HALF_BITS;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   function automatic logic [7:0] bayer_threshold(input logic x0, input logic y0);
      logic [7:0] t;
      case ({y0, x0})
         2'b00:   t = BAYER_T00;
         2'b01:   t = BAYER_T10;
         2'b10:   t = BAYER_T01;
         default: t = BAYER_T11;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/memlcd_dither.sv
// rtl/memlcd_dither.sv - 1-bit per channel quantizer, ordered dither or fixed threshold
module memlcd_dither
   import memlcd_pkg::*;
#(
   parameter int DITHER = 1
) (
   input  logic [23:0]          i_rgb,
   input  logic                 i_x0,
   input  logic                 i_y0,
   output logic [HALF_BITS-1:0] o_bits
);

   logic [7:0] thr;

   always_comb begin
      thr    = (DITHER != 0) ? bayer_threshold(i_x0, i_y0) : FIXED_THRESHOLD;
      o_bits = {i_rgb[7:0] >= thr, i_rgb[15:8] >= thr, i_rgb[23:16] >= thr};
   end

endmodule

// File: rtl/memlcd_pixel_packer.sv
// rtl/memlcd_pixel_packer.sv - quantizes RGB888 pixels, packs pairs into 6-bit FIFO words
// and tracks frame position for the memory-LCD line driver.
module memlcd_pixel_packer
   import memlcd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int H_PIXELS   = H_PIXELS_DEFAULT,
   parameter int V_LINES    = V_LINES_DEFAULT,
   parameter int DITHER     = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_pix_valid,
   input  logic [23:0]           i_pix_rgb,
   input  logic                  i_pix_sof,
   output logic                  o_pix_ready,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic                  o_winc,
   input  logic                  i_wfull,
   output logic                  o_frame_done,
   output logic                  o_err_sync
);

   localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
   localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);

   state_e               state_q, state_d;
   logic [XW-1:0]        x_q, x_d;
   logic [YW-1:0]        y_q, y_d;
   logic [HALF_BITS-1:0] half_q, half_d;
   logic [WORD_BITS-1:0] word_q, word_d;
   logic                 out_valid_q, out_valid_d;
   logic                 last_q, last_d;
   logic                 frame_done_q, frame_done_d;
   logic                 err_sync_q, err_sync_d;

   logic                 accept;
   logic                 sof_acc;
   logic                 take;
   logic                 misplaced;
   logic                 write;
   logic                 pix_last;
   logic [XW-1:0]        cur_x;
   logic [YW-1:0]        cur_y;
   logic [HALF_BITS-1:0] pix_bits;

   // A SOF always re-anchors the accepted pixel at (0,0), whatever the counters say
   always_comb begin
      accept    = i_pix_valid & o_pix_ready;
      sof_acc   = accept & i_pix_sof;
      take      = sof_acc | (accept & (state_q == ACTIVE));
      misplaced = sof_acc & (state_q == ACTIVE) & ((x_q != '0) | (y_q != '0));
      cur_x     = sof_acc ? '0 : x_q;
      cur_y     = sof_acc ? '0 : y_q;
      pix_last  = (cur_x == X_LAST) & (cur_y == Y_LAST);
      write     = out_valid_q & ~i_wfull;
   end

   memlcd_dither #(
      .DITHER (DITHER)
   ) u_dither (
      .i_rgb  (i_pix_rgb),
      .i_x0   (cur_x[0]),
      .i_y0   (cur_y[0]),
      .o_bits (pix_bits)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (take) state_d = ACTIVE;
         ACTIVE: if (take && pix_last) state_d = IDLE;
      endcase
   end

   always_comb begin
      o_pix_ready = 1'b1;
      if (state_q == ACTIVE) begin
         o_pix_ready = ~out_valid_q | ~i_wfull;
      end
   end

   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      half_d       = half_q;
      word_d       = word_q;
      out_valid_d  = out_valid_q;
      last_d       = last_q;
      frame_done_d = write & last_q;
      err_sync_d   = misplaced;

      if (write) begin
         out_valid_d = 1'b0;
         last_d      = 1'b0;
      end

      if (take) begin
         if (cur_x == X_LAST) begin
            x_d = '0;
            y_d = (cur_y == Y_LAST) ? '0 : cur_y + Y_ONE;
         end else begin
            x_d = cur_x + X_ONE;
            y_d = cur_y;
         end

         // A load on the same edge as a write wins, so the freshly packed word stays valid
         if (cur_x[0]) begin
            word_d[WORD_LSB_PIX1 +: HALF_BITS] = pix_bits;
            word_d[WORD_LSB_PIX0 +: HALF_BITS] = half_q;
            out_valid_d                        = 1'b1;
            last_d                             = pix_last;
         end else begin
            half_d = pix_bits;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         x_q          <= '0;
         y_q          <= '0;
         half_q       <= '0;
         word_q       <= '0;
         out_valid_q  <= 1'b0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_sync_q   <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         half_q       <= half_d;
         word_q       <= word_d;
         out_valid_q  <= out_valid_d;
         last_q       <= last_d;
         frame_done_q <= frame_done_d;
         err_sync_q   <= err_sync_d;
      end
   end

   always_comb begin
      o_wdata                = '0;
      o_wdata[WORD_BITS-1:0] = word_q;
   end

   assign o_winc       = write;
   assign o_frame_done = frame_done_q;
   assign o_err_sync   = err_sync_q;

endmodule
